frame_pixel_writer: RTL and testbench
=====================================

// Module: frame_pixel_writer
// PURPOSE
//   Frame-buffer side of the rasterizer pixel interface. Accepts pixel writes (x, y, color)
//   from the rasterizer and turns them into linear write cycles into a double-buffered pixel RAM.
//   Drives frame_ready to throttle the rasterizer. On raster_done it swaps the front and back
//   buffers at the next display vblank.
// PARAMETERS
//   H_RES   640  visible pixels per line; x >= H_RES is out of range
//   V_RES   480  visible lines; y >= V_RES is out of range
//   ADDR_W  19   per-buffer linear address width (H_RES*V_RES <= 2**ADDR_W)
// PORTS
//   clk          in   1         system clock
//   rst          in   1         synchronous reset, active-low
//   px_wr        in   1         pixel write strobe from rasterizer (its frame_rd_en)
//   px_x         in   10        pixel x
//   px_y         in   9         pixel y
//   px_color     in   3         pixel color
//   raster_done  in   1         one-cycle pulse: frame fully rasterized
//   vblank       in   1         display vertical blank (level, synchronous to clk)
//   frame_ready  out  1         rasterizer may issue px_wr / raster_done
//   mem_we       out  1         RAM write enable
//   mem_addr     out  ADDR_W+1  {back_buf_sel, y*H_RES+x}
//   mem_wdata    out  3         RAM write data
//   disp_sel     out  1         buffer currently scanned out (front)
// BEHAVIOUR
//   - Reset (rst==0 at clk edge): state=INIT; frame_ready=0, mem_we=0, mem_addr=0,
//     mem_wdata=0, disp_sel=0; back buffer = ~disp_sel = 1.
//   - FSM states:
//       INIT -> ACCEPT unconditionally.
//       ACCEPT: frame_ready=1. raster_done=1 -> WAIT_VB.
//       WAIT_VB: frame_ready=0. vblank=1 and no write in flight -> SWAP.
//       SWAP: toggle disp_sel; frame_ready=0; -> ACCEPT. frame_ready is high again 1 cycle later.
//   - frame_ready is registered and is a decode of the state.
//   - Write accept: px_wr && frame_ready. Else px_wr is ignored (protocol violation, no write).
//   - Latency: 1 cycle. Pixel accepted in cycle N gives mem_we=1 in cycle N+1 with the
//     registered mem_addr and mem_wdata. mem_we is a 1-cycle pulse per pixel.
//   - Back-to-back px_wr is sustained at 1 pixel per clock.
//   - Address: y*H_RES + x, computed shift-add for 640 ((y<<9)+(y<<7)+x), zero-extended to ADDR_W.
//     The MSB is the back buffer (~disp_sel) sampled in the accept cycle.
//   - Out of range (px_x>=H_RES or px_y>=V_RES): accepted but dropped. mem_we stays 0.
//   - px_wr and raster_done in the same cycle: the pixel is written, then the FSM goes to WAIT_VB.
//     The pixel lands in the old back buffer before the swap.
//   - raster_done while not in ACCEPT: ignored.
//   - vblank already high on entry to WAIT_VB: SWAP the next cycle, after the in-flight write retires.
//   - Reset mid-frame: aborts. No further mem_we; buffers return to disp_sel=0.
// CONFIGURATION
//   FB_DROP_COUNT_EN defined adds:
//     - output px_count [18:0]: pixels written to the RAM this frame.
//     - output drop_count [15:0]: out-of-range pixels this frame; saturates at 16'hFFFF.
//     - Both clear in SWAP and on reset.
//   Undefined: neither port exists and no counter logic is built.
// STRUCTURE
//   - Shared include fb_defs.vh: H_RES/V_RES defaults, state encodings
//     (INIT=2'd0, ACCEPT=2'd1, WAIT_VB=2'd2, SWAP=2'd3), COLOR_W=3.
//   - Sub-module fb_addr_calc: combinational px_x, px_y -> linear addr plus in_range flag.
//     Instantiated once.
// TESTING
//   1 Reset, release: frame_ready 0, then 1 on the second edge after release; disp_sel=0.
//   2 px_wr x=5,y=2,c=3b101 -> next cycle mem_we=1, mem_addr={1'b1,19'd1285}, mem_wdata=5.
//   3 Write x=639,y=479 -> mem_addr low bits = 307199. Write x=640,y=0 -> no mem_we;
//     drop_count=1 with FB_DROP_COUNT_EN.
//   4 4 back-to-back px_wr -> 4 consecutive mem_we cycles, addresses in order.
//   5 px_wr with raster_done together, vblank low 10 cycles then high -> pixel written,
//     frame_ready low until SWAP, disp_sel 0->1, next write uses MSB 0.
//   6 px_wr while frame_ready=0 -> no mem_we. Reset in WAIT_VB -> INIT, disp_sel=0.

Source files
------------

// File: rtl/frame_pixel_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_pixel_writer_pkg
// Shared definitions for the frame-buffer pixel writer: default raster
// geometry, pixel coordinate/color widths and the control FSM state encoding.
// Imported by frame_pixel_writer and fb_addr_calc.
// -----------------------------------------------------------------------------
package frame_pixel_writer_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int ADDR_W_DEF = 19;
    localparam int COLOR_W    = 3;
    localparam int X_W        = 10;
    localparam int Y_W        = 9;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_ACCEPT  = 2'd1,
        ST_WAIT_VB = 2'd2,
        ST_SWAP    = 2'd3
    } fb_state_e;

endpackage

// File: rtl/frame_pixel_writer_addr_calc.sv
// -----------------------------------------------------------------------------
// fb_addr_calc
// Combinational pixel coordinate to linear buffer address translation.
// Ports:
//   i_x        pixel x coordinate
//   i_y        pixel y coordinate
//   o_addr     y*H_RES + x, zero-extended to ADDR_W
//   o_in_range 1 when x < H_RES and y < V_RES
// -----------------------------------------------------------------------------
module fb_addr_calc
    import frame_pixel_writer_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [X_W-1:0]    i_x,
    input  logic [Y_W-1:0]    i_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_range
);

    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_y_ext;

    assign w_x_ext = ADDR_W'(i_x);
    assign w_y_ext = ADDR_W'(i_y);

    generate
        if (H_RES == 640) begin : g_shift_add
            // 640 = 512 + 128, so the row offset is two shifts and an add
            assign o_addr = (w_y_ext << 9) + (w_y_ext << 7) + w_x_ext;
        end else begin : g_mult
            localparam logic [ADDR_W-1:0] H_RES_L = ADDR_W'(H_RES);
            assign o_addr = w_y_ext * H_RES_L + w_x_ext;
        end
    endgenerate

    assign o_in_range = (i_x < X_W'(H_RES)) && (i_y < Y_W'(V_RES));

endmodule

// File: rtl/frame_pixel_writer.sv
// -----------------------------------------------------------------------------
// frame_pixel_writer
// Frame-buffer side of the rasterizer pixel interface. Turns (x, y, color)
// pixel writes into linear write cycles into a double-buffered pixel RAM and
// swaps front/back buffers at the first vblank after raster_done.
// Optional feature macro: FB_DROP_COUNT_EN (adds per-frame pixel/drop counters).
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-low
//   i_px_wr        pixel write strobe from rasterizer
//   i_px_x/i_px_y  pixel coordinates
//   i_px_color     pixel color
//   i_raster_done  one-cycle pulse: frame fully rasterized
//   i_vblank       display vertical blank level
//   o_frame_ready  rasterizer may issue px_wr / raster_done
//   o_mem_we       RAM write enable (one pulse per written pixel)
//   o_mem_addr     {back buffer select, y*H_RES+x}
//   o_mem_wdata    RAM write data
//   o_disp_sel     buffer currently scanned out
//   o_px_count     (FB_DROP_COUNT_EN) pixels written this frame
//   o_drop_count   (FB_DROP_COUNT_EN) out-of-range pixels this frame, saturating
// -----------------------------------------------------------------------------
module frame_pixel_writer
    import frame_pixel_writer_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_px_wr,
    input  logic [X_W-1:0]     i_px_x,
    input  logic [Y_W-1:0]     i_px_y,
    input  logic [COLOR_W-1:0] i_px_color,
    input  logic               i_raster_done,
    input  logic               i_vblank,
    output logic               o_frame_ready,
    output logic               o_mem_we,
    output logic [ADDR_W:0]    o_mem_addr,
    output logic [COLOR_W-1:0] o_mem_wdata,
    output logic               o_disp_sel
`ifdef FB_DROP_COUNT_EN
    ,
    output logic [18:0]        o_px_count,
    output logic [15:0]        o_drop_count
`endif
);

    fb_state_e          r_state;
    fb_state_e          w_state_nxt;
    logic               r_frame_ready;
    logic               r_mem_we;
    logic [ADDR_W:0]    r_mem_addr;
    logic [COLOR_W-1:0] r_mem_wdata;
    logic               r_disp_sel;

    logic [ADDR_W-1:0]  w_lin_addr;
    logic               w_in_range;
    logic               w_accept;

    fb_addr_calc #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_calc (
        .i_x        (i_px_x),
        .i_y        (i_px_y),
        .o_addr     (w_lin_addr),
        .o_in_range (w_in_range)
    );

    assign w_accept = i_px_wr && r_frame_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:    w_state_nxt = ST_ACCEPT;
            ST_ACCEPT:  if (i_raster_done) w_state_nxt = ST_WAIT_VB;
            // r_mem_we high means a write is still being presented to the RAM
            ST_WAIT_VB: if (i_vblank && !r_mem_we) w_state_nxt = ST_SWAP;
            ST_SWAP:    w_state_nxt = ST_ACCEPT;
            default:    w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= ST_INIT;
            r_frame_ready <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_disp_sel    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Ready only while staying in ACCEPT: drops together with the
            // move to WAIT_VB, and rises one cycle after re-entering ACCEPT.
            r_frame_ready <= (r_state == ST_ACCEPT) && (w_state_nxt == ST_ACCEPT);
            r_mem_we      <= w_accept && w_in_range;
            if (w_accept) begin
                // Back buffer is sampled here, so a pixel accepted alongside
                // raster_done still lands in the pre-swap back buffer.
                r_mem_addr  <= {~r_disp_sel, w_lin_addr};
                r_mem_wdata <= i_px_color;
            end
            if (r_state == ST_SWAP) begin
                r_disp_sel <= ~r_disp_sel;
            end
        end
    end

    assign o_frame_ready = r_frame_ready;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_disp_sel    = r_disp_sel;

`ifdef FB_DROP_COUNT_EN
    logic [18:0] r_px_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst || (r_state == ST_SWAP)) begin
            r_px_count   <= '0;
            r_drop_count <= '0;
        end else if (w_accept) begin
            if (w_in_range) begin
                r_px_count <= r_px_count + 19'd1;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign o_px_count   = r_px_count;
    assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_frame_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_frame_pixel_writer
// Directed bench for frame_pixel_writer. Inputs are driven 1 ns after the
// rising edge; outputs are sampled at that same point, after the edge has
// settled.
// -----------------------------------------------------------------------------
module tb_frame_pixel_writer;
    import frame_pixel_writer_pkg::*;

    logic               clk;
    logic               rst;
    logic               px_wr;
    logic [X_W-1:0]     px_x;
    logic [Y_W-1:0]     px_y;
    logic [COLOR_W-1:0] px_color;
    logic               raster_done;
    logic               vblank;
    logic               frame_ready;
    logic               mem_we;
    logic [19:0]        mem_addr;
    logic [COLOR_W-1:0] mem_wdata;
    logic               disp_sel;
`ifdef FB_DROP_COUNT_EN
    logic [18:0]        px_count;
    logic [15:0]        drop_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    frame_pixel_writer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_px_wr       (px_wr),
        .i_px_x        (px_x),
        .i_px_y        (px_y),
        .i_px_color    (px_color),
        .i_raster_done (raster_done),
        .i_vblank      (vblank),
        .o_frame_ready (frame_ready),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_disp_sel    (disp_sel)
`ifdef FB_DROP_COUNT_EN
        ,
        .o_px_count    (px_count),
        .o_drop_count  (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic wr, input int x, input int y, input int c);
        px_wr    = wr;
        px_x     = X_W'(x);
        px_y     = Y_W'(y);
        px_color = COLOR_W'(c);
    endtask

    initial begin
        rst = 1'b0;
        set_px(1'b0, 0, 0, 0);
        raster_done = 1'b0;
        vblank      = 1'b0;
        #1;
        repeat (3) step();

        // Reset state
        check("rst_frame_ready", 32'(frame_ready), 32'd0);
        check("rst_mem_we",      32'(mem_we),      32'd0);
        check("rst_mem_addr",    32'(mem_addr),    32'd0);
        check("rst_mem_wdata",   32'(mem_wdata),   32'd0);
        check("rst_disp_sel",    32'(disp_sel),    32'd0);

        // Release: ready on the second edge after release
        rst = 1'b1;
        step();
        check("rel_edge1_ready", 32'(frame_ready), 32'd0);
        step();
        check("rel_edge2_ready", 32'(frame_ready), 32'd1);

        // Single pixel x=5 y=2 -> 2*640+5 = 1285, back buffer 1
        set_px(1'b1, 5, 2, 5);
        step();
        set_px(1'b0, 0, 0, 0);
        check("px1_we",    32'(mem_we),    32'd1);
        check("px1_addr",  32'(mem_addr),  32'h80505);
        check("px1_wdata", 32'(mem_wdata), 32'd5);
        step();
        check("px1_we_pulse", 32'(mem_we), 32'd0);

        // Corner pixel 479*640+639 = 307199, then x out of range
        set_px(1'b1, 639, 479, 1);
        step();
        check("corner_we",   32'(mem_we), 32'd1);
        check("corner_addr", 32'(mem_addr[18:0]), 32'd307199);
        set_px(1'b1, 640, 0, 2);
        step();
        set_px(1'b0, 0, 0, 0);
        check("oor_x_we", 32'(mem_we), 32'd0);
        set_px(1'b1, 3, 480, 2);
        step();
        set_px(1'b0, 0, 0, 0);
        check("oor_y_we", 32'(mem_we), 32'd0);
        step();
`ifdef FB_DROP_COUNT_EN
        check("drop_count", 32'(drop_count), 32'd2);
        check("px_count",   32'(px_count),   32'd2);
`endif

        // Four back-to-back pixels on row 1: addresses 650..653
        for (int i = 0; i < 4; i++) begin
            set_px(1'b1, 10 + i, 1, i);
            step();
            check("b2b_we",   32'(mem_we),   32'd1);
            check("b2b_addr", 32'(mem_addr), 32'h80000 + 32'd650 + 32'(i));
        end
        set_px(1'b0, 0, 0, 0);
        step();
        check("b2b_end_we", 32'(mem_we), 32'd0);

        // Pixel together with raster_done, vblank low for 10 cycles
        set_px(1'b1, 7, 3, 2);
        raster_done = 1'b1;
        step();
        set_px(1'b0, 0, 0, 0);
        raster_done = 1'b0;
        check("rd_px_we",    32'(mem_we),      32'd1);
        check("rd_px_addr",  32'(mem_addr),    32'h80000 + 32'd1927);
        check("rd_ready_lo", 32'(frame_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("wait_ready", 32'(frame_ready), 32'd0);
            check("wait_disp",  32'(disp_sel),    32'd0);
        end
        vblank = 1'b1;
        step();
        check("swap_state_disp", 32'(disp_sel), 32'd0);
        step();
        vblank = 1'b0;
        check("swap_disp",  32'(disp_sel),    32'd1);
        check("swap_ready", 32'(frame_ready), 32'd0);
        step();
        check("swap_ready_back", 32'(frame_ready), 32'd1);
`ifdef FB_DROP_COUNT_EN
        check("swap_px_count",   32'(px_count),   32'd0);
        check("swap_drop_count", 32'(drop_count), 32'd0);
`endif
        set_px(1'b1, 1, 0, 6);
        step();
        set_px(1'b0, 0, 0, 0);
        check("new_back_we",   32'(mem_we),    32'd1);
        check("new_back_addr", 32'(mem_addr),  32'd1);
        check("new_back_data", 32'(mem_wdata), 32'd6);

        // Writes ignored while frame_ready is low
        raster_done = 1'b1;
        step();
        raster_done = 1'b0;
        check("wvb_ready", 32'(frame_ready), 32'd0);
        set_px(1'b1, 2, 2, 3);
        step();
        check("ignored_we", 32'(mem_we), 32'd0);
        step();
        set_px(1'b0, 0, 0, 0);
        check("ignored_we2", 32'(mem_we), 32'd0);

        // Reset while waiting for vblank
        rst = 1'b0;
        step();
        check("midrst_disp",  32'(disp_sel),    32'd0);
        check("midrst_ready", 32'(frame_ready), 32'd0);
        check("midrst_we",    32'(mem_we),      32'd0);
        rst = 1'b1;
        step();
        step();
        check("rerel_ready", 32'(frame_ready), 32'd1);

        // vblank already high when entering WAIT_VB: hold for the in-flight write
        vblank = 1'b1;
        set_px(1'b1, 0, 1, 4);
        raster_done = 1'b1;
        step();
        set_px(1'b0, 0, 0, 0);
        raster_done = 1'b0;
        check("vbhi_we",   32'(mem_we),   32'd1);
        check("vbhi_addr", 32'(mem_addr), 32'h80000 + 32'd640);
        step();
        check("vbhi_hold_disp", 32'(disp_sel), 32'd0);
        step();
        check("vbhi_swap_disp", 32'(disp_sel), 32'd0);
        step();
        check("vbhi_done_disp", 32'(disp_sel), 32'd1);
        vblank = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
